// File: rtl/dqsbuf_rdtrain_pkg.sv
// -----------------------------------------------------------------------------
// dqsbuf_rdtrain_pkg
// Shared types and constants for the DQSBUF read-delay training controller:
//   - state_t      : main training FSM states
//   - seq_phase_t  : phases of the PAUSE/UPDATE/PAUSE commit sequence
//   - RDLOADN_IDLE : inactive level of the active-low RDLOADN pin
//   - DEF_*        : default timing parameters
//   - is_busy_state: states in which training is considered in progress
// -----------------------------------------------------------------------------
package dqsbuf_rdtrain_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_MOVE,
    ST_CALC,
    ST_RELOAD,
    ST_STEP,
    ST_GAP,
    ST_UPD,
    ST_DONE,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_PRE,
    SEQ_UPD,
    SEQ_POST
  } seq_phase_t;

  localparam logic RDLOADN_IDLE = 1'b1;

  localparam int DEF_SETTLE_CYC   = 8;
  localparam int DEF_PAUSE_CYC    = 4;
  localparam int DEF_LOCK_TIMEOUT = 4096;

  function automatic logic is_busy_state(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL));
  endfunction

endpackage

// File: rtl/dqsbuf_update_seq.sv
// -----------------------------------------------------------------------------
// dqsbuf_update_seq
// Commits a new DQSBUF read delay: PAUSE high for PAUSE_CYC cycles, then
// UPDATE high for one cycle with PAUSE still high, then PAUSE high for
// PAUSE_CYC more cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_start   : one-cycle request; PAUSE rises on the following cycle
//   i_abort   : drops PAUSE/UPDATE at once and returns to idle
//   o_pause   : registered, to DQSBUF PAUSE
//   o_update  : registered, to DQSBUF UPDATE
//   o_done    : high during the last PAUSE cycle of the sequence
// -----------------------------------------------------------------------------
module dqsbuf_update_seq
  import dqsbuf_rdtrain_pkg::*;
#(
  parameter int PAUSE_CYC = DEF_PAUSE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_abort,
  output logic o_pause,
  output logic o_update,
  output logic o_done
);

  localparam int            CW   = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAUSE_CYC - 1);

  seq_phase_t    r_phase,  w_phase_nxt;
  logic [CW-1:0] r_cnt,    w_cnt_nxt;
  logic          r_pause,  w_pause_nxt;
  logic          r_update, w_update_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= SEQ_IDLE;
      r_cnt    <= '0;
      r_pause  <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pause  <= w_pause_nxt;
      r_update <= w_update_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_cnt_nxt    = r_cnt;
    w_pause_nxt  = r_pause;
    w_update_nxt = 1'b0;
    if (i_abort) begin
      w_phase_nxt = SEQ_IDLE;
      w_cnt_nxt   = '0;
      w_pause_nxt = 1'b0;
    end else begin
      case (r_phase)
        SEQ_IDLE: begin
          if (i_start) begin
            w_phase_nxt = SEQ_PRE;
            w_cnt_nxt   = '0;
            w_pause_nxt = 1'b1;
          end
        end
        SEQ_PRE: begin
          if (r_cnt == LAST) begin
            w_phase_nxt  = SEQ_UPD;
            w_cnt_nxt    = '0;
            w_update_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        SEQ_UPD: begin
          w_phase_nxt = SEQ_POST;
          w_cnt_nxt   = '0;
        end
        SEQ_POST: begin
          if (r_cnt == LAST) begin
            w_phase_nxt = SEQ_IDLE;
            w_cnt_nxt   = '0;
            w_pause_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_phase_nxt = SEQ_IDLE;
          w_cnt_nxt   = '0;
          w_pause_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_pause  = r_pause;
  assign o_update = r_update;
  // Lets the caller leave its wait state on the same edge PAUSE falls.
  assign o_done   = (r_phase == SEQ_POST) && (r_cnt == LAST);

endmodule

// File: rtl/dqsbuf_rdtrain_ctrl.sv
// -----------------------------------------------------------------------------
// dqsbuf_rdtrain_ctrl
// Read-delay training for one DQSBUF_CORE DQS group. After DDRDLL lock it
// sweeps the read delay from 0 upward (RDLOADN then RDMOVE), samples
// BURSTDETECT at each code, reloads the delay to the centre of the passing
// window and commits it through a PAUSE-guarded UPDATE.
// Optional feature: define DQSBUF_RDTRAIN_LOCK_TIMEOUT_EN to fail training
// after LOCK_TIMEOUT consecutive cycles in WAIT_LOCK without lock.
// Ports:
//   clk, rst        : clock (SCLK domain), synchronous active-high reset
//   start           : level, honoured only when idle/done/failed
//   dll_lock        : DDRDLL lock (synchronous)
//   burst_det       : DQSBUF BURSTDETECT (synchronous)
//   pause, update   : DQSBUF PAUSE / UPDATE
//   rdloadn, rdmove : DQSBUF RDLOADN (active low) / RDMOVE
//   rddirection     : DQSBUF RDDIRECTION, tied to increment
//   busy/done/fail  : training status; done/fail sticky until next start
//   delay_code      : tap position tracked by the controller
//   win_lo, win_hi  : first/last passing code of the window
// -----------------------------------------------------------------------------
module dqsbuf_rdtrain_ctrl
  import dqsbuf_rdtrain_pkg::*;
#(
  parameter int DELAY_W      = 7,
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int PAUSE_CYC    = DEF_PAUSE_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dll_lock,
  input  logic               burst_det,
  output logic               pause,
  output logic               update,
  output logic               rdloadn,
  output logic               rdmove,
  output logic               rddirection,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [DELAY_W-1:0] delay_code,
  output logic [DELAY_W-1:0] win_lo,
  output logic [DELAY_W-1:0] win_hi
);

  localparam logic [DELAY_W-1:0] MAX_CODE    = '1;
  localparam int                 SCW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0]     SETTLE_LAST = SCW'(SETTLE_CYC - 1);

  if (DELAY_W < 1 || SETTLE_CYC < 1 || PAUSE_CYC < 1 || LOCK_TIMEOUT < 1) begin : g_bad_cfg
    $error("dqsbuf_rdtrain_ctrl: DELAY_W, SETTLE_CYC, PAUSE_CYC and LOCK_TIMEOUT must be >= 1");
  end

  // Centre of [lo, hi]; the sum needs one extra bit before the halving.
  function automatic logic [DELAY_W-1:0] window_centre(input logic [DELAY_W-1:0] lo,
                                                       input logic [DELAY_W-1:0] hi);
    logic [DELAY_W:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return DELAY_W'(sum >> 1);
  endfunction

  state_t             r_state,      w_state_nxt;
  logic [SCW-1:0]     r_settle_cnt, w_settle_cnt_nxt;
  logic               r_found,      w_found_nxt;
  logic [DELAY_W-1:0] r_delay,      w_delay_nxt;
  logic [DELAY_W-1:0] r_win_lo,     w_win_lo_nxt;
  logic [DELAY_W-1:0] r_win_hi,     w_win_hi_nxt;
  logic [DELAY_W-1:0] r_target,     w_target_nxt;
  logic               r_busy,       w_busy_nxt;
  logic               r_done,       w_done_nxt;
  logic               r_fail,       w_fail_nxt;
  logic               r_rdloadn,    w_rdloadn_nxt;
  logic               r_rdmove,     w_rdmove_nxt;

  logic w_abort;
  logic w_lock_expired;
  logic w_seq_start;
  logic w_seq_done;

  // Lock loss is only meaningful once the sweep has started.
  assign w_abort = is_busy_state(r_state) && (r_state != ST_WAIT_LOCK) && !dll_lock;

`ifdef DQSBUF_RDTRAIN_LOCK_TIMEOUT_EN
  localparam int             LCW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);

  logic [LCW-1:0] r_lock_cnt;

  // Held at zero outside WAIT_LOCK so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_WAIT_LOCK)) r_lock_cnt <= '0;
    else                                  r_lock_cnt <= r_lock_cnt + LCW'(1);
  end

  assign w_lock_expired = (r_lock_cnt == LOCK_LAST);
`else
  assign w_lock_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_found      <= 1'b0;
      r_delay      <= '0;
      r_win_lo     <= '0;
      r_win_hi     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_rdloadn    <= RDLOADN_IDLE;
      r_rdmove     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_found      <= w_found_nxt;
      r_delay      <= w_delay_nxt;
      r_win_lo     <= w_win_lo_nxt;
      r_win_hi     <= w_win_hi_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_fail       <= w_fail_nxt;
      r_rdloadn    <= w_rdloadn_nxt;
      r_rdmove     <= w_rdmove_nxt;
    end
  end

  // Target is only read after CALC has written it.
  always_ff @(posedge clk) begin
    r_target <= w_target_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_found_nxt      = r_found;
    w_delay_nxt      = r_delay;
    w_win_lo_nxt     = r_win_lo;
    w_win_hi_nxt     = r_win_hi;
    w_target_nxt     = r_target;

    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          w_state_nxt  = ST_WAIT_LOCK;
          w_found_nxt  = 1'b0;
          w_win_lo_nxt = '0;
          w_win_hi_nxt = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (dll_lock)            w_state_nxt = ST_LOAD;
        else if (w_lock_expired) w_state_nxt = ST_FAIL;
      end
      ST_LOAD, ST_MOVE: begin
        w_state_nxt      = ST_SETTLE;
        w_settle_cnt_nxt = '0;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt      = ST_SAMPLE;
          w_settle_cnt_nxt = '0;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + SCW'(1);
        end
      end
      ST_SAMPLE: begin
        if (burst_det) begin
          w_win_hi_nxt = r_delay;
          if (!r_found) begin
            w_win_lo_nxt = r_delay;
            w_found_nxt  = 1'b1;
          end
        end
        // A failing sample after the window opened closes it.
        if (!burst_det && r_found)      w_state_nxt = ST_CALC;
        else if (r_delay == MAX_CODE)   w_state_nxt = (burst_det || r_found) ? ST_CALC : ST_FAIL;
        else                            w_state_nxt = ST_MOVE;
      end
      ST_CALC: begin
        w_target_nxt = window_centre(r_win_lo, r_win_hi);
        w_state_nxt  = ST_RELOAD;
      end
      ST_RELOAD: begin
        w_state_nxt = (r_target == '0) ? ST_UPD : ST_STEP;
      end
      ST_STEP: begin
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        w_state_nxt = (r_delay == r_target) ? ST_UPD : ST_STEP;
      end
      ST_UPD: begin
        if (w_seq_done) w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt      = ST_WAIT_LOCK;
      w_settle_cnt_nxt = '0;
      w_found_nxt      = 1'b0;
    end

    // delay_code mirrors the taps: cleared on each load, bumped on each move.
    if ((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RELOAD)) begin
      w_delay_nxt = '0;
    end else if ((w_state_nxt == ST_MOVE) || (w_state_nxt == ST_STEP)) begin
      w_delay_nxt = r_delay + DELAY_W'(1);
    end
  end

  // Pin outputs are decoded from the next state so they register in step
  // with the state they belong to.
  always_comb begin
    w_busy_nxt    = is_busy_state(w_state_nxt);
    w_done_nxt    = (w_state_nxt == ST_DONE);
    w_fail_nxt    = (w_state_nxt == ST_FAIL);
    w_rdloadn_nxt = ((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RELOAD)) ? ~RDLOADN_IDLE
                                                                             : RDLOADN_IDLE;
    w_rdmove_nxt  = (w_state_nxt == ST_MOVE) || (w_state_nxt == ST_STEP);
  end

  assign w_seq_start = (w_state_nxt == ST_UPD) && (r_state != ST_UPD);

  dqsbuf_update_seq #(
    .PAUSE_CYC (PAUSE_CYC)
  ) u_update_seq (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_seq_start),
    .i_abort  (w_abort),
    .o_pause  (pause),
    .o_update (update),
    .o_done   (w_seq_done)
  );

  assign rdloadn     = r_rdloadn;
  assign rdmove      = r_rdmove;
  assign rddirection = 1'b0;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fail        = r_fail;
  assign delay_code  = r_delay;
  assign win_lo      = r_win_lo;
  assign win_hi      = r_win_hi;

endmodule
